car_detect_conditioner: RTL

CAR_DETECT_CONDITIONER -- requirements
Module: car_detect_conditioner

---
 rtl/car_detect_conditioner.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/car_detect_conditioner.sv
// Loop-detector conditioner: two-flop synchronizer, debounce FSM and pending-car counter.
// Optional stuck-vehicle detector is enabled by defining STUCK_DET_EN.
module car_detect_conditioner #(
    parameter int WL           = 4,
    parameter int DEB_CYCLES   = 8,
    parameter int STUCK_CYCLES = 200
) (
    input  logic          CLK,
    input  logic          RST_N,
    input  logic          Sensor,
    input  logic          Ack,
    output logic          Car,
    output logic [WL-1:0] Car_Count,
    output logic          Arrival,
    output logic          Overflow,
    output logic          Stuck
);

    if (DEB_CYCLES < 2 || DEB_CYCLES > 255) begin : g_bad_deb
        $error("DEB_CYCLES out of range");
    end

    if (STUCK_CYCLES <= DEB_CYCLES || STUCK_CYCLES > 65535) begin : g_bad_stuck
        $error("STUCK_CYCLES out of range");
    end

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        PRESENT,
        REL
    } state_t;

    localparam logic [7:0]    CNT_LAST = 8'(DEB_CYCLES - 1);
    localparam logic [WL-1:0] CNT_MAX  = '1;
    localparam logic [WL-1:0] CNT_ONE  = WL'(1);

    state_t        state_q;
    logic [7:0]    cnt_q;
    logic          s1_q;
    logic          s_q;
    logic          arr_q;
    logic          arr_ev;
    logic [WL-1:0] count_q;
    logic [WL-1:0] count_d;
    logic          ovf_q;
    logic          ovf_d;
    logic          car_q;
    logic          car_d;
    logic          ack_ok;
    logic          stuck_q;
    logic          stuck_d;

    // Two-flop synchronizer for the asynchronous loop level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            s1_q <= 1'b0;
            s_q  <= 1'b0;
        end else begin
            s1_q <= Sensor;
            s_q  <= s1_q;
        end
    end

    assign arr_ev = (state_q == ARM) && s_q && (cnt_q == CNT_LAST);

    // Debounce FSM; cnt restarts on every state change.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            arr_q   <= 1'b0;
        end else begin
            arr_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (s_q) begin
                        state_q <= ARM;
                        cnt_q   <= '0;
                    end
                end
                ARM: begin
                    if (!s_q) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else if (arr_ev) begin
                        state_q <= PRESENT;
                        cnt_q   <= '0;
                        arr_q   <= 1'b1;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                PRESENT: begin
                    if (!s_q) begin
                        state_q <= REL;
                        cnt_q   <= '0;
                    end
                end
                REL: begin
                    if (s_q) begin
                        state_q <= PRESENT;
                        cnt_q   <= '0;
                    end else if (cnt_q == CNT_LAST) begin
                        state_q <= IDLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + 8'd1;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

`ifdef STUCK_DET_EN
    localparam logic [15:0] HOLD_LAST = 16'(STUCK_CYCLES - 1);

    logic [15:0] hold_q;
    logic        in_hold;

    assign in_hold = (state_q == PRESENT) && s_q;
    assign stuck_d = in_hold && (stuck_q || (hold_q == HOLD_LAST));

    // Hold counter measures time spent in PRESENT; leaving PRESENT clears it.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            hold_q  <= '0;
            stuck_q <= 1'b0;
        end else begin
            stuck_q <= stuck_d;
            if (!in_hold) begin
                hold_q <= '0;
            end else if (hold_q != HOLD_LAST) begin
                hold_q <= hold_q + 16'd1;
            end
        end
    end
`else
    assign stuck_d = 1'b0;
    assign stuck_q = 1'b0;
`endif

    // A stuck vehicle freezes the count, so Ack is ignored meanwhile.
    always_comb begin
        ack_ok  = Ack && !stuck_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        if (arr_ev && !ack_ok) begin
            if (count_q == CNT_MAX) begin
                ovf_d = 1'b1;
            end else begin
                count_d = count_q + CNT_ONE;
            end
        end else if (!arr_ev && ack_ok && (count_q != '0)) begin
            count_d = count_q - CNT_ONE;
        end
        car_d = (count_d != '0) || stuck_d;
    end

    // Pending counter, sticky overflow and request level.
    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            count_q <= '0;
            ovf_q   <= 1'b0;
            car_q   <= 1'b0;
        end else begin
            count_q <= count_d;
            ovf_q   <= ovf_d;
            car_q   <= car_d;
        end
    end

    assign Car       = car_q;
    assign Car_Count = count_q;
    assign Arrival   = arr_q;
    assign Overflow  = ovf_q;
    assign Stuck     = stuck_q;

endmodule
